// File: rtl/sipo_word_assembler_pkg.sv
// Shared types and helpers for the serial-in / parallel-out word assembler.
package sipo_word_assembler_pkg;

    // One-entry output buffer occupancy.
    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

    // Width of the partial-word bit counter for a given word width.
    function automatic int unsigned cnt_w(input int unsigned width);
        return 32'($clog2(width)) + 32'd1;
    endfunction

endpackage : sipo_word_assembler_pkg

// File: rtl/sipo_bit_collector.sv
// Shift register plus bit counter that assembles WIDTH serial bits into a word.
//   clk, reset    : clock, async active-high reset
//   clear_i       : sync clear of the partial word (wins over bit_valid_i)
//   serial_i      : serial data bit, sampled when bit_valid_i is high
//   bit_valid_i   : qualifies serial_i on this edge
//   word_c        : assembled word including the bit sampled this edge
//   word_done_c   : high when this edge samples the last bit of a word
//   bit_count_o   : bits held in the current partial word (never WIDTH)
module sipo_bit_collector
    import sipo_word_assembler_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear_i,
    input  logic                      serial_i,
    input  logic                      bit_valid_i,
    output logic [WIDTH-1:0]          word_c,
    output logic                      word_done_c,
    output logic [cnt_w(WIDTH)-1:0]   bit_count_o
);

    localparam int unsigned CNT_W = cnt_w(WIDTH);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shifted_c;
    logic             last_bit_c;

    // Insertion point depends on bit order.
    if (MSB_FIRST) begin : g_msb_first
        assign shifted_c = {sr_q[WIDTH-2:0], serial_i};
    end else begin : g_lsb_first
        assign shifted_c = {serial_i, sr_q[WIDTH-1:1]};
    end

    assign last_bit_c  = bit_valid_i && (cnt_q == CNT_W'(WIDTH - 1));
    assign word_done_c = last_bit_c && !clear_i;
    assign word_c      = shifted_c;
    assign bit_count_o = cnt_q;

    // Next-state for the shift register and counter.
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (bit_valid_i) begin
            sr_d  = shifted_c;
            cnt_d = last_bit_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule : sipo_bit_collector

// File: rtl/sipo_word_assembler.sv
// Serial-to-parallel word assembler with a one-entry valid/ready output buffer
// and a sticky overrun flag for words completed while the buffer is occupied.
//   clk, reset  : clock, async active-high reset
//   clear       : sync clear of partial word, buffer and overrun
//   serial_in   : serial data bit
//   bit_valid   : samples serial_in on this edge
//   word_out    : buffered word (held stable while word_valid)
//   word_valid  : buffer holds an unconsumed word
//   word_ready  : downstream accepts word_out on this edge
//   bit_count   : bits collected in the current partial word
//   overrun     : sticky, set when a completed word is dropped
module sipo_word_assembler
    import sipo_word_assembler_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      serial_in,
    input  logic                      bit_valid,
    output logic [WIDTH-1:0]          word_out,
    output logic                      word_valid,
    input  logic                      word_ready,
    output logic [cnt_w(WIDTH)-1:0]   bit_count,
    output logic                      overrun
);

    buf_state_e       state_q;
    logic [WIDTH-1:0] word_q;
    logic             overrun_q;
    logic [WIDTH-1:0] word_c;
    logic             word_done_c;

    sipo_bit_collector #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_collector (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (clear),
        .serial_i    (serial_in),
        .bit_valid_i (bit_valid),
        .word_c      (word_c),
        .word_done_c (word_done_c),
        .bit_count_o (bit_count)
    );

    // Buffer FSM and overrun flag; clear wins over completion and handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= BUF_EMPTY;
            word_q    <= '0;
            overrun_q <= 1'b0;
        end else if (clear) begin
            state_q   <= BUF_EMPTY;
            overrun_q <= 1'b0;
        end else begin
            case (state_q)
                BUF_EMPTY: begin
                    if (word_done_c) begin
                        word_q  <= word_c;
                        state_q <= BUF_FULL;
                    end
                end
                BUF_FULL: begin
                    if (word_done_c && word_ready) begin
                        // zero-bubble handoff: old word leaves, new one lands
                        word_q <= word_c;
                    end else if (word_done_c) begin
                        // buffer occupied: keep old word, drop the new one
                        overrun_q <= 1'b1;
                    end else if (word_ready) begin
                        state_q <= BUF_EMPTY;
                    end
                end
                default: state_q <= BUF_EMPTY;
            endcase
        end
    end

    assign word_out   = word_q;
    assign word_valid = (state_q == BUF_FULL);
    assign overrun    = overrun_q;

endmodule : sipo_word_assembler

// File: tb/tb_sipo_word_assembler.sv
module tb_sipo_word_assembler;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic       serial_in;
    logic       bit_valid;
    logic       word_ready;
    logic       ready_l;
    logic [3:0] word_out, word_out_l;
    logic       word_valid, word_valid_l;
    logic [2:0] bit_count, bit_count_l;
    logic       overrun, overrun_l;

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] exp_q[$];
    logic [3:0] mon_exp;

    always #5 clk = ~clk;

    sipo_word_assembler #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .serial_in  (serial_in),
        .bit_valid  (bit_valid),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .bit_count  (bit_count),
        .overrun    (overrun)
    );

    sipo_word_assembler #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .serial_in  (serial_in),
        .bit_valid  (bit_valid),
        .word_out   (word_out_l),
        .word_valid (word_valid_l),
        .word_ready (ready_l),
        .bit_count  (bit_count_l),
        .overrun    (overrun_l)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        serial_in = b;
        bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
    endtask

    // Monitor: a handshake is due on the next edge whenever valid and ready are seen here.
    always @(negedge clk) begin
        if (!reset && word_valid && word_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_word: got %0h with no word expected", word_out);
            end else begin
                mon_exp = exp_q.pop_front();
                n_cmp++;
                if (word_out !== mon_exp) begin
                    n_bad++;
                    $display("FAIL accepted_word: got %0h expected %0h", word_out, mon_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; clear = 1'b0; serial_in = 1'b0; bit_valid = 1'b0;
        word_ready = 1'b0; ready_l = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_bit_count", 32'(bit_count), 32'd0);
        check("rst_word_valid", 32'(word_valid), 32'd0);
        check("rst_word_out", 32'(word_out), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);

        // Reset mid-word, then 1,0,1,1
        send_bit(1'b1);
        send_bit(1'b1);
        check("pre_reset_count", 32'(bit_count), 32'd2);
        reset = 1'b1;
        #2;
        check("async_reset_count", 32'(bit_count), 32'd0);
        reset = 1'b0;
        exp_q.push_back(4'b1011);
        send_bit(1'b1);
        check("cnt_after_b1", 32'(bit_count), 32'd1);
        check("valid_after_b1", 32'(word_valid), 32'd0);
        send_bit(1'b0);
        check("cnt_after_b2", 32'(bit_count), 32'd2);
        send_bit(1'b1);
        check("cnt_after_b3", 32'(bit_count), 32'd3);
        check("valid_after_b3", 32'(word_valid), 32'd0);
        send_bit(1'b1);
        check("cnt_after_b4", 32'(bit_count), 32'd0);
        check("valid_after_b4", 32'(word_valid), 32'd1);
        check("word_1011", 32'(word_out), 32'hb);
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        check("valid_after_accept", 32'(word_valid), 32'd0);

        // Back-to-back: second word completes on the same edge the first is taken
        exp_q.push_back(4'b1100);
        exp_q.push_back(4'b0101);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        check("b2b_word1", 32'(word_out), 32'hc);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        check("b2b_valid_held", 32'(word_valid), 32'd1);
        word_ready = 1'b1;
        send_bit(1'b1);
        check("b2b_valid_handoff", 32'(word_valid), 32'd1);
        check("b2b_word2", 32'(word_out), 32'h5);
        check("b2b_overrun", 32'(overrun), 32'd0);
        tick();
        word_ready = 1'b0;
        check("b2b_drained", 32'(word_valid), 32'd0);

        // Overrun: 1010 buffered, 1111 dropped
        exp_q.push_back(4'b1010);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        check("ovr_word_kept", 32'(word_out), 32'ha);
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_count", 32'(bit_count), 32'd0);
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        check("ovr_drained", 32'(word_valid), 32'd0);
        check("ovr_sticky", 32'(overrun), 32'd1);

        // Gaps between bits give the same word as a contiguous stream
        exp_q.push_back(4'b0110);
        send_bit(1'b0); tick();
        send_bit(1'b1); tick(); tick();
        check("gap_count", 32'(bit_count), 32'd2);
        send_bit(1'b1); tick();
        send_bit(1'b0);
        check("gap_word", 32'(word_out), 32'h6);
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;

        // Clear with buffer full and bit_count=3 (buffered word discarded)
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        check("clr_pre_count", 32'(bit_count), 32'd3);
        check("clr_pre_valid", 32'(word_valid), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_count", 32'(bit_count), 32'd0);
        check("clr_valid", 32'(word_valid), 32'd0);
        check("clr_overrun", 32'(overrun), 32'd0);

        // Clear beats the 4th bit on the same edge
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        clear = 1'b1;
        send_bit(1'b1);
        clear = 1'b0;
        check("clrpri_count", 32'(bit_count), 32'd0);
        check("clrpri_valid", 32'(word_valid), 32'd0);
        tick();
        check("clrpri_valid_later", 32'(word_valid), 32'd0);

        // LSB-first vs MSB-first on the same stream 1,0,0,0
        exp_q.push_back(4'b1000);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
        check("lsb_word", 32'(word_out_l), 32'h1);
        check("lsb_valid", 32'(word_valid_l), 32'd1);
        check("msb_word", 32'(word_out), 32'h8);
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        tick();

        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_sipo_word_assembler
